// File: rtl/pc_rx_packet_stream.sv
`default_nettype none
// ============================================================================
// Module   : pc_rx_packet_stream
// Purpose  : PC-side UART receive path. Holds a 2FF-synchronised 8N1 UART
//            receiver, a byte-framed packet decoder (SYNC, CMD, LEN_HI,
//            LEN_LO, LEN*WORD_BYTES payload bytes), an N-byte word assembler
//            and a show-ahead payload FIFO. It also provides inter-byte
//            timeout resync, counting of framing errors, overflow flagging
//            and variable-length packets.
// Ports    : i_clock, i_reset_n (async, active low), i_rx_serial (async line),
//            i_read_next (pop head), i_clear_errors (clear sticky errors);
//            o_packet_cmd, o_packet_start/done/abort, o_reset_req (pulses),
//            o_fifo_word/o_fifo_empty/o_fifo_count (FIFO head and status),
//            o_overflow (sticky), o_frame_err_cnt (saturating).
// Config   : define PC_RX_PARITY_EN for a 9th even-parity bit before stop.
// Revision : 1.0 - initial release
// ============================================================================
module pc_rx_packet_stream #(
   parameter int          CLKS_PER_BIT = 435,
   parameter int          WORD_BYTES   = 4,
   parameter int          FIFO_DEPTH   = 16,
   parameter int          TIMEOUT_BITS = 32,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic                          i_clock,
   input  logic                          i_reset_n,
   input  logic                          i_rx_serial,
   input  logic                          i_read_next,
   input  logic                          i_clear_errors,
   output logic [7:0]                    o_packet_cmd,
   output logic                          o_packet_start,
   output logic                          o_packet_done,
   output logic                          o_packet_abort,
   output logic                          o_reset_req,
   output logic [8*WORD_BYTES-1:0]       o_fifo_word,
   output logic                          o_fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
   output logic                          o_overflow,
   output logic [7:0]                    o_frame_err_cnt
);
   localparam int              CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam int              TO_LIMIT  = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int              TW        = $clog2(TO_LIMIT) + 1;
   localparam logic [TW-1:0]   TO_LAST   = TW'(TO_LIMIT - 1);
   localparam int              WORD_W    = 8 * WORD_BYTES;
   localparam int              BCW       = $clog2(WORD_BYTES) + 1;
   localparam logic [BCW-1:0]  BYTE_LAST = BCW'(WORD_BYTES - 1);
   localparam int              AW        = $clog2(FIFO_DEPTH);
   localparam int              CNTW      = AW + 1;
   localparam logic [CNTW-1:0] FIFO_FULL = CNTW'(FIFO_DEPTH);

   // ------------------------------------------------------------ UART receiver
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_t;

   rx_state_t      rx_state_q, rx_state_d;
   logic           rx_meta_q, rx_sync_q;
   logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]     bit_idx_q, bit_idx_d;
   logic [7:0]     shift_q, shift_d;
   logic [7:0]     byte_q, byte_d;
   logic           byte_valid_q, byte_valid_d;
   logic           frame_err_q, frame_err_d;
`ifdef PC_RX_PARITY_EN
   logic           par_q, par_d;
`endif

   always_comb begin
      rx_state_d   = rx_state_q;
      bit_cnt_d    = bit_cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      byte_d       = byte_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
`ifdef PC_RX_PARITY_EN
      par_d        = par_q;
`endif
      case (rx_state_q)
         RX_IDLE: if (!rx_sync_q) begin
            rx_state_d = RX_START;
            bit_cnt_d  = '0;
         end
         RX_START: if (bit_cnt_q == HALF_LAST) begin
            // Line back high at mid start bit means a glitch, not a frame.
            bit_cnt_d  = '0;
            bit_idx_d  = '0;
            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
         end else bit_cnt_d = bit_cnt_q + 1'b1;
         RX_DATA: if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) begin
`ifdef PC_RX_PARITY_EN
               rx_state_d = RX_PARITY;
`else
               rx_state_d = RX_STOP;
`endif
            end
         end else bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef PC_RX_PARITY_EN
         RX_PARITY: if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d  = '0;
            par_d      = rx_sync_q;
            rx_state_d = RX_STOP;
         end else bit_cnt_d = bit_cnt_q + 1'b1;
`endif
         RX_STOP: if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (!rx_sync_q) begin
               // Bad stop: count it and wait for an idle line before re-arming.
               frame_err_d = 1'b1;
               rx_state_d  = RX_WAIT;
            end else begin
               rx_state_d = RX_IDLE;
`ifdef PC_RX_PARITY_EN
               if ((^shift_q) == par_q) begin
                  byte_d       = shift_q;
                  byte_valid_d = 1'b1;
               end else frame_err_d = 1'b1;
`else
               byte_d       = shift_q;
               byte_valid_d = 1'b1;
`endif
            end
         end else bit_cnt_d = bit_cnt_q + 1'b1;
         RX_WAIT: if (rx_sync_q) rx_state_d = RX_IDLE;
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ----------------------------------------------------------- packet decoder
   typedef enum logic [2:0] {P_IDLE, P_CMD, P_LEN_HI, P_LEN_LO, P_PAYLOAD, P_DONE} pkt_state_t;

   pkt_state_t        pkt_state_q, pkt_state_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [15:0]       len_q, len_d;
   logic [15:0]       word_cnt_q, word_cnt_d;
   logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
   logic [WORD_W-1:0] word_sr_q, word_sr_d;
   logic [TW-1:0]     to_cnt_q, to_cnt_d;
   logic              start_q, start_d, done_q, done_d, abort_q, abort_d, rreq_q, rreq_d;
   logic              w_timeout, w_push;
   logic [WORD_W-1:0] w_push_word;

   always_comb begin
      pkt_state_d = pkt_state_q;
      cmd_d       = cmd_q;
      len_d       = len_q;
      word_cnt_d  = word_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      word_sr_d   = word_sr_q;
      start_d     = 1'b0;
      done_d      = 1'b0;
      abort_d     = 1'b0;
      rreq_d      = 1'b0;
      w_push      = 1'b0;
      // Earlier bytes sit in the upper lanes: first byte ends up as MS byte.
      w_push_word = WORD_W'({word_sr_q, byte_q});
      to_cnt_d    = (pkt_state_q == P_IDLE || byte_valid_q) ? '0 : to_cnt_q + 1'b1;
      w_timeout   = (pkt_state_q != P_IDLE) && (to_cnt_q == TO_LAST);

      if (pkt_state_q != P_IDLE && (w_timeout || frame_err_q)) begin
         abort_d     = 1'b1;
         pkt_state_d = P_IDLE;
      end else begin
         case (pkt_state_q)
            P_IDLE:   if (byte_valid_q && byte_q == SYNC_BYTE) pkt_state_d = P_CMD;
            P_CMD:    if (byte_valid_q) begin
               cmd_d       = byte_q;
               start_d     = 1'b1;
               pkt_state_d = P_LEN_HI;
            end
            P_LEN_HI: if (byte_valid_q) begin
               len_d       = {byte_q, len_q[7:0]};
               pkt_state_d = P_LEN_LO;
            end
            P_LEN_LO: if (byte_valid_q) begin
               len_d      = {len_q[15:8], byte_q};
               word_cnt_d = '0;
               byte_cnt_d = '0;
               if ({len_q[15:8], byte_q} == 16'd0) begin
                  done_d      = 1'b1;
                  rreq_d      = (cmd_q == 8'hFF);
                  pkt_state_d = P_DONE;
               end else pkt_state_d = P_PAYLOAD;
            end
            P_PAYLOAD: if (byte_valid_q) begin
               if (byte_cnt_q == BYTE_LAST) begin
                  w_push     = 1'b1;
                  byte_cnt_d = '0;
                  if (word_cnt_q == len_q - 16'd1) begin
                     done_d      = 1'b1;
                     rreq_d      = (cmd_q == 8'hFF);
                     pkt_state_d = P_DONE;
                  end else word_cnt_d = word_cnt_q + 16'd1;
               end else begin
                  word_sr_d  = w_push_word;
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end
            P_DONE:   pkt_state_d = P_IDLE;
            default:  pkt_state_d = P_IDLE;
         endcase
      end
   end

   // --------------------------------------------------------------- word FIFO
   logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]   count_q, count_d;
   logic              ovf_q, ovf_d;
   logic [7:0]        err_q, err_d;
   logic              w_pop, w_wr;

   always_comb begin
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      w_pop    = i_read_next && (count_q != '0);
      w_wr     = w_push && ((count_q != FIFO_FULL) || w_pop);
      wr_ptr_d = w_wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = w_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (w_wr && !w_pop)      count_d = count_q + 1'b1;
      else if (!w_wr && w_pop) count_d = count_q - 1'b1;
      ovf_d = i_clear_errors ? 1'b0 : (ovf_q | (w_push & ~w_wr));
      err_d = err_q;
      if (i_clear_errors)                     err_d = '0;
      else if (frame_err_q && err_q != 8'hFF) err_d = err_q + 8'd1;
   end

   always_ff @(posedge i_clock) begin
      if (w_wr) mem_q[wr_ptr_q] <= w_push_word;
   end

   // -------------------------------------------------------------- registers
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_state_q   <= RX_IDLE;
         bit_cnt_q    <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         byte_q       <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef PC_RX_PARITY_EN
         par_q        <= 1'b0;
`endif
         pkt_state_q  <= P_IDLE;
         cmd_q        <= '0;
         len_q        <= '0;
         word_cnt_q   <= '0;
         byte_cnt_q   <= '0;
         word_sr_q    <= '0;
         to_cnt_q     <= '0;
         start_q      <= 1'b0;
         done_q       <= 1'b0;
         abort_q      <= 1'b0;
         rreq_q       <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         ovf_q        <= 1'b0;
         err_q        <= '0;
      end else begin
         rx_meta_q    <= i_rx_serial;
         rx_sync_q    <= rx_meta_q;
         rx_state_q   <= rx_state_d;
         bit_cnt_q    <= bit_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
`ifdef PC_RX_PARITY_EN
         par_q        <= par_d;
`endif
         pkt_state_q  <= pkt_state_d;
         cmd_q        <= cmd_d;
         len_q        <= len_d;
         word_cnt_q   <= word_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         word_sr_q    <= word_sr_d;
         to_cnt_q     <= to_cnt_d;
         start_q      <= start_d;
         done_q       <= done_d;
         abort_q      <= abort_d;
         rreq_q       <= rreq_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         ovf_q        <= ovf_d;
         err_q        <= err_d;
      end
   end

   assign o_packet_cmd    = cmd_q;
   assign o_packet_start  = start_q;
   assign o_packet_done   = done_q;
   assign o_packet_abort  = abort_q;
   assign o_reset_req     = rreq_q;
   assign o_fifo_empty    = (count_q == '0);
   assign o_fifo_word     = o_fifo_empty ? '0 : mem_q[rd_ptr_q];
   assign o_fifo_count    = count_q;
   assign o_overflow      = ovf_q;
   assign o_frame_err_cnt = err_q;

endmodule
`default_nettype wire
